ccff_loader: RTL and testbench

Configuration-chain driver for the FPGA fabric's `prog_clk`/`ccff_head`/`ccff_tail` shift chain. It is the writer end of the chain: it serializes a byte stream from the host onto `ccff_head` and generates `prog_clk` from `clk`. It also provides a non-destructive readback mode that recirculates `ccff_tail` into `ccff_head` and returns the chain contents as bytes. It sits between the host-side input pins/controller and `fpga_top`.

---
 rtl/ccff_loader.sv | 123 ++++++++++++
 tb/tb_ccff_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: configuration-chain writer and non-destructive readback driver generating prog_clk
module ccff_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       prog_clk,
  output logic       ccff_head,
  input  logic       ccff_tail,
  output logic       busy,
  output logic       done
);
  localparam int BW = $clog2(CHAIN_LEN + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] LAST = BW'(CHAIN_LEN - 1);
  localparam logic [DW-1:0] DLAST = DW'(CLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LO, HI, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic mode_q, mode_n;
  logic [BW-1:0] bitcnt, bitcnt_n;
  logic [2:0] bytepos, bytepos_n;
  logic [DW-1:0] div, div_n;
  logic [7:0] shreg, shreg_n, rdsh, rdsh_n, rd_data_n;
  logic head_n, rd_valid_n, free, phase_end, byte_end, stall;
  // Next-state and next-output logic; head/tail sampling happens on entry to LO so head is stable a full LO phase before the edge
  always_comb begin
    state_n = state;
    mode_n = mode_q;
    bitcnt_n = bitcnt;
    bytepos_n = bytepos;
    div_n = div;
    shreg_n = shreg;
    rdsh_n = rdsh;
    head_n = ccff_head;
    rd_data_n = rd_data;
    rd_valid_n = rd_valid & ~rd_ready;
    free = ~rd_valid | rd_ready;
    phase_end = div == DLAST;
    byte_end = bytepos == 3'd7;
    stall = mode_q & byte_end & ~free;
    case (state)
      IDLE: if (start) begin
        mode_n = mode;
        bitcnt_n = '0;
        bytepos_n = '0;
        state_n = mode ? LO : FETCH;
      end
      FETCH: if (wr_valid) begin
        shreg_n = wr_data;
        bytepos_n = '0;
        state_n = LO;
      end
      LO: if (phase_end) state_n = HI; else div_n = div + 1'b1;
      HI: if (!phase_end) div_n = div + 1'b1;
        else if (!stall) begin
          bitcnt_n = bitcnt + 1'b1;
          bytepos_n = bytepos + 1'b1;
          shreg_n = {shreg[6:0], 1'b0};
          if (mode_q && byte_end) begin
            rd_data_n = rdsh;
            rd_valid_n = 1'b1;
          end
          state_n = (bitcnt == LAST) ? (mode_q ? FLUSH : DONE) : (!mode_q && byte_end) ? FETCH : LO;
        end
      FLUSH: if (free) begin
        if (bytepos != '0) begin
          rd_data_n = rdsh << (4'd8 - {1'b0, bytepos});
          rd_valid_n = 1'b1;
          bytepos_n = '0;
        end else state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) div_n = '0;
    if (state_n == LO && state != LO) begin
      head_n = mode_n ? ccff_tail : shreg_n[7];
      if (mode_n) rdsh_n = {rdsh[6:0], ccff_tail};
    end
  end
  // State and registered outputs; reset forces IDLE and drops prog_clk and any pending read byte
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mode_q <= 1'b0;
      bitcnt <= '0;
      bytepos <= '0;
      div <= '0;
      shreg <= '0;
      rdsh <= '0;
      ccff_head <= 1'b0;
      rd_data <= '0;
      rd_valid <= 1'b0;
      prog_clk <= 1'b0;
      wr_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      mode_q <= mode_n;
      bitcnt <= bitcnt_n;
      bytepos <= bytepos_n;
      div <= div_n;
      shreg <= shreg_n;
      rdsh <= rdsh_n;
      ccff_head <= head_n;
      rd_data <= rd_data_n;
      rd_valid <= rd_valid_n;
      prog_clk <= state_n == HI;
      wr_ready <= state_n == FETCH;
      busy <= state_n != IDLE && state_n != DONE;
      done <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: scoreboard bench with a bit-level chain model for ccff_loader
module tb_ccff_loader;
  localparam int N = 12;
  localparam int D = 2;
  logic clk = 0, reset = 1, start = 0, mode = 0, wr_valid = 0, rd_ready = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data;
  logic wr_ready, rd_valid, prog_clk, ccff_head, ccff_tail, busy, done;
  logic [N-1:0] chain = 0;
  bit exp_head[$];
  logic [7:0] exp_rd[$];
  int checks = 0, passes = 0, edges = 0, hs = 0, dones = 0, cyc = 0, done_cyc = 0, st_cyc = 0;
  bit rd_rand = 0, pc_prev = 0;

  ccff_loader #(.CHAIN_LEN(N), .CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .prog_clk(prog_clk), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .busy(busy), .done(done)
  );

  assign ccff_tail = chain[N-1];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rd_rand) begin #1; rd_ready = 1'($urandom_range(0, 1)); end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: chain model shifts on each prog_clk rise; head bits and read bytes are popped from the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (prog_clk && !pc_prev) begin
        edges++;
        chain = {chain[N-2:0], ccff_head};
        if (exp_head.size() == 0) begin
          checks++;
          $display("FAIL extra_edge: head %0b with no expected bit", ccff_head);
        end else chk("head_bit", 32'(ccff_head), 32'(exp_head.pop_front()));
      end
      if (wr_valid && wr_ready) hs++;
      if (wr_ready) chk("fetch_pclk_low", 32'(prog_clk), 0);
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL extra_rd: got %0h with no expected byte", rd_data);
        end else chk("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
    end
    pc_prev = prog_clk;
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go(bit m);
    mode = m;
    start = 1;
    st_cyc = cyc;
    tick();
    start = 0;
    mode = 0;
  endtask

  task automatic send(logic [7:0] b, int gap);
    int t = 0;
    bit h = 0;
    tick(gap);
    wr_data = b;
    wr_valid = 1;
    while (!h && t < 500) begin
      @(negedge clk);
      h = wr_ready;
      @(posedge clk); #1;
      t++;
    end
    wr_valid = 0;
    if (!h) begin
      checks++;
      $display("FAIL send_timeout: no handshake after %0d cycles", t);
    end
  endtask

  task automatic wait_done(string name, int d0);
    int t = 0;
    while (dones == d0 && t < 2000) begin tick(); t++; end
    if (dones == d0) begin
      checks++;
      $display("FAIL %s_timeout: no done after %0d cycles", name, t);
    end
  endtask

  task automatic do_write(logic [7:0] b0, logic [7:0] b1, int g0, int g1, int lat, bit poke);
    logic [15:0] w;
    int e0, h0, d0;
    w = {b0, b1};
    e0 = edges; h0 = hs; d0 = dones;
    for (int i = 0; i < N; i++) exp_head.push_back(w[15-i]);
    go(0);
    chk("busy_rise", 32'(busy), 1);
    send(b0, g0);
    if (poke) begin
      tick(3);
      mode = 1;
      start = 1;
      tick();
      start = 0;
      mode = 0;
    end
    send(b1, g1);
    wait_done("write", d0);
    chk("write_edges", 32'(edges - e0), N);
    chk("write_handshakes", 32'(hs - h0), 2);
    chk("write_done_pulses", 32'(dones - d0), 1);
    chk("write_chain", 32'(chain), 32'(w[15:4]));
    chk("write_latency", 32'(done_cyc - st_cyc), 32'(lat));
    chk("head_queue_empty", 32'(exp_head.size()), 0);
    tick(2);
    chk("idle_busy_low", 32'(busy), 0);
  endtask

  task automatic do_read(logic [N-1:0] pre, bit rnd, int hold);
    int e0, d0, t;
    chain = pre;
    e0 = edges; d0 = dones;
    for (int i = 0; i < N; i++) exp_head.push_back(pre[N-1-i]);
    exp_rd.push_back(pre[N-1 -: 8]);
    exp_rd.push_back({pre[3:0], 4'h0});
    rd_ready = (!rnd && hold == 0);
    rd_rand = rnd;
    go(1);
    if (hold > 0) begin
      t = 0;
      while (!rd_valid && t < 200) begin tick(); t++; end
      chk("hold_first_valid", 32'(rd_valid), 1);
      tick(hold);
      chk("hold_valid_kept", 32'(rd_valid), 1);
      chk("hold_data_kept", 32'(rd_data), 32'(pre[N-1 -: 8]));
      chk("hold_no_done", 32'(dones - d0), 0);
      chk("hold_busy", 32'(busy), 1);
      rd_ready = 1;
    end
    wait_done("read", d0);
    rd_rand = 0;
    tick(2);
    rd_ready = 0;
    chk("read_edges", 32'(edges - e0), N);
    chk("read_chain_intact", 32'(chain), 32'(pre));
    chk("read_done_pulses", 32'(dones - d0), 1);
    chk("rd_queue_empty", 32'(exp_rd.size()), 0);
    chk("read_valid_dropped", 32'(rd_valid), 0);
  endtask

  initial begin
    int e0, d0, h0, t;
    logic [7:0] b0, b1;
    int g0, g1;
    tick(3);
    chk("rst_prog_clk", 32'(prog_clk), 0);
    chk("rst_head", 32'(ccff_head), 0);
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 0;
    tick(2);
    // wr_valid in IDLE must not handshake
    h0 = hs;
    wr_data = 8'h3C;
    wr_valid = 1;
    tick(5);
    wr_valid = 0;
    chk("idle_no_handshake", 32'(hs - h0), 0);
    do_write(8'hA5, 8'hF0, 0, 0, N * 2 * D + (N + 7) / 8 + 1, 0);
    do_write(8'hA5, 8'hF0, 0, 37, N * 2 * D + (N + 7) / 8 + 1 + 5, 0);
    do_write(8'h5A, 8'h90, 0, 0, N * 2 * D + (N + 7) / 8 + 1, 1);
    do_read(12'hABC, 0, 0);
    do_read(12'hABC, 0, 20);
    // reset during the 5th bit of a write
    e0 = edges; d0 = dones;
    for (int i = 0; i < 8; i++) exp_head.push_back(1'(8'hC3 >> (7 - i)));
    go(0);
    send(8'hC3, 0);
    t = 0;
    while (edges - e0 < 4 && t < 200) begin tick(); t++; end
    chk("pre_reset_edges", 32'(edges - e0), 4);
    tick(2);
    reset = 1;
    tick();
    chk("mid_reset_prog_clk", 32'(prog_clk), 0);
    chk("mid_reset_busy", 32'(busy), 0);
    reset = 0;
    exp_head.delete();
    tick(20);
    chk("mid_reset_no_done", 32'(dones - d0), 0);
    chk("mid_reset_no_edges", 32'(edges - e0), 4);
    do_write(8'h81, 8'h7E, 0, 0, N * 2 * D + (N + 7) / 8 + 1, 0);
    // randomized writes followed by randomized-backpressure readbacks of the written contents
    for (int k = 0; k < 4; k++) begin
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      g0 = $urandom_range(0, 3);
      g1 = $urandom_range(0, 3);
      do_write(b0, b1, g0, g1, N * 2 * D + (N + 7) / 8 + 1 + g0, 0);
      do_read({b0, b1[7:4]}, 1, 0);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
